pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the six-stage core. It turns per-stage stall requests into the `stall[5:0]` vector consumed by the pc, if/id, id/ex, ex/mem, mem/wb and write-back registers. It also turns exception types from the mem stage into a flush pulse and a redirect PC. An optional stall watchdog breaks pipeline hangs by injecting a synthetic flush after a long continuous stall.

## Interface
- `WDOG_W`, 8: width of the consecutive-stall counter.
- `WDOG_LIMIT`, 200: number of consecutive stall cycles that triggers a watchdog flush. Must satisfy 1 ≤ `WDOG_LIMIT` < 2^`WDOG_W`.
- `WDOG_VECTOR`, 32'h0000_0060: redirect PC used for a watchdog flush.

- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `stallreq_if` in 1: fetch stage requests a stall.
- `stallreq_id` in 1: decode stage requests a stall.
- `stallreq_ex` in 1: execute stage requests a stall.
- `stallreq_mem` in 1: mem stage requests a stall.
- `excepttype_i` in 32: exception type from the mem stage; 0 means no exception.
- `cp0_epc_i` in 32: current EPC, already forwarded.
- `stall` out 6: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 means stop.
- `flush` out 1: clears all pipeline registers at the next edge.
- `new_pc` out 32: redirect target. Valid only while `flush`=1, otherwise 0.
- `wdog_flag` out 1: sticky; set when any watchdog flush has occurred.

## Operation
- State register `st` has three states: RUN, STALL, WDOG. There is one counter, `scnt` (`WDOG_W` bits).
- Exception decode is combinational and applies in any state. If `excepttype_i` != 0, then `flush`=1 and `stall`=6'b000000. `new_pc` is decoded as:
  - 0x1 → 0x20
  - 0x8, 0x9, 0xa, 0xc, 0xd → 0x40
  - 0xe → `cp0_epc_i`
  - any other nonzero value → 0x40
- Stall decode is combinational and applies only when there is no exception and `st` != WDOG. The highest-priority active request sets the vector:
  - `stallreq_mem` → 6'b011111
  - `stallreq_ex` → 6'b001111
  - `stallreq_id` → 6'b000111
  - `stallreq_if` → 6'b000011
  - none → 6'b000000
- In WDOG with no exception: `flush`=1, `new_pc`=`WDOG_VECTOR`, `stall`=0.
- A real exception in the WDOG cycle takes precedence for `new_pc`. The WDOG state is still consumed, and `wdog_flag` is still set.
- `scnt` and `st` transitions, each clock edge:
  - Flush this cycle (exception or WDOG): `scnt`←0, `st`←RUN.
  - Else, any stall request active:
    - if `scnt` = `WDOG_LIMIT`-1: `st`←WDOG, `scnt`←0.
    - otherwise: `scnt`←`scnt`+1, `st`←STALL.
  - Else (no request): `scnt`←0, `st`←RUN.
- `wdog_flag` is set on the edge that leaves WDOG. It is cleared only by `rst`.

## Timing
- Reset (asynchronous, immediate): `st`=RUN, `scnt`=0, `wdog_flag`=0. The combinational outputs then follow their inputs: `stall` reflects the requests; `flush`=0 and `new_pc`=0 when there is no exception.
- `stall`, `flush` and `new_pc` are combinational from the inputs and `st`, with zero-cycle latency. The pipeline registers act on the following edge.
- Watchdog timing:
  - A request held continuously for `WDOG_LIMIT` cycles puts the block in WDOG in cycle `WDOG_LIMIT`+1.
  - The flush is exactly one cycle wide.
  - `wdog_flag` is visible the cycle after the flush.
- A request that drops for even one cycle restarts the count from 0.
- Reset asserted mid-stall or in WDOG: the state is lost immediately and no flush completes.

## Configuration
- `PIPE_WDOG_EN` defined: `scnt`, the WDOG state and `wdog_flag` logic are compiled in as described above.
- `PIPE_WDOG_EN` undefined:
  - No counter; `st` is effectively always RUN or STALL.
  - `wdog_flag` is tied to 0.
  - Stalls of any length never cause a flush.
  - `stall`, `flush` and `new_pc` behave identically otherwise.

## Test plan
- Priority: `stallreq_if`=1 and `stallreq_ex`=1 together → `stall`=6'b001111. Add `stallreq_mem`=1 → 6'b011111.
- Exception decode: `excepttype_i`=0x8 → `flush`=1, `new_pc`=0x40, `stall`=0. Then `excepttype_i`=0xe with `cp0_epc_i`=0x1234 → `new_pc`=0x1234.
- Watchdog: `WDOG_LIMIT`=4, `stallreq_id` held high → `stall`=6'b000111 for 4 cycles. Cycle 5 gives `flush`=1, `new_pc`=0x60, `stall`=0. `wdog_flag`=1 from cycle 6 and stays set.
- Count restart: `WDOG_LIMIT`=4, request pattern 1,1,1,0,1,1,1 → no flush ever.
- Simultaneous events: WDOG cycle coincides with `excepttype_i`=0x1 → `new_pc`=0x20, `flush`=1. `wdog_flag` is set next cycle and `st` returns to RUN.
- Reset mid-stall: `rst` pulsed after 3 stall cycles → `wdog_flag`=0 and the count restarts. Without `PIPE_WDOG_EN`, a 1000-cycle stall → no flush.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, exception flush/redirect and an optional
// stall watchdog (compiled in when PIPE_WDOG_EN is defined).
module pipe_ctrl #(
    parameter int unsigned WDOG_W      = 8,
    parameter int unsigned WDOG_LIMIT  = 200,
    parameter logic [31:0] WDOG_VECTOR = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdog_flag
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StWdog  = 2'd2
    } st_e;

    st_e        st_q, st_d;
    logic       exc;
    logic       any_req;
    logic       wdog_now;
    logic [5:0] stall_dec;

    assign exc     = |excepttype_i;
    assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

    // Deeper stage request freezes everything upstream of it as well.
    always_comb begin
        stall_dec = 6'b000000;
        if (stallreq_mem) begin
            stall_dec = 6'b011111;
        end else if (stallreq_ex) begin
            stall_dec = 6'b001111;
        end else if (stallreq_id) begin
            stall_dec = 6'b000111;
        end else if (stallreq_if) begin
            stall_dec = 6'b000011;
        end
    end

    // A real exception overrides the watchdog redirect target.
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (exc) begin
            flush = 1'b1;
            case (excepttype_i)
                32'h1:                                new_pc = 32'h0000_0020;
                32'h8, 32'h9, 32'ha, 32'hc, 32'hd:    new_pc = 32'h0000_0040;
                32'he:                                new_pc = cp0_epc_i;
                default:                              new_pc = 32'h0000_0040;
            endcase
        end else if (wdog_now) begin
            flush  = 1'b1;
            new_pc = WDOG_VECTOR;
        end else begin
            stall = stall_dec;
        end
    end

`ifdef PIPE_WDOG_EN
    localparam logic [WDOG_W-1:0] LimitM1 = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] scnt_q, scnt_d;
    logic              wdog_flag_q;

    assign wdog_now  = (st_q == StWdog);
    assign wdog_flag = wdog_flag_q;

    always_comb begin
        scnt_d = '0;
        st_d   = StRun;
        if (!flush && any_req) begin
            if (scnt_q == LimitM1) begin
                st_d = StWdog;
            end else begin
                scnt_d = scnt_q + WDOG_W'(1);
                st_d   = StStall;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= StRun;
            scnt_q      <= '0;
            wdog_flag_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            scnt_q      <= scnt_d;
            wdog_flag_q <= wdog_flag_q | wdog_now;
        end
    end
`else
    logic unused_cfg;

    assign wdog_now   = 1'b0;
    assign wdog_flag  = 1'b0;
    assign unused_cfg = ^{WDOG_W, WDOG_LIMIT, WDOG_VECTOR, st_q};

    always_comb begin
        st_d = StRun;
        if (!flush && any_req) begin
            st_d = StStall;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= StRun;
        end else begin
            st_q <= st_d;
        end
    end
`endif

endmodule
